// File: rtl/spart_fifo.sv
// Buffered full-duplex UART. It has a TX FIFO and an RX FIFO, a 16x-oversampled
// receiver, optional parity, and sticky error flags. It sits behind the
// processor I/O bus.

// Circular FIFO. The pointers carry one extra wrap bit, so full and empty can be
// told apart by comparing that bit.
module spart_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module spart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter logic [15:0] DIV_RESET  = 16'd162
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_state_t;

  tx_state_t            tx_state;
  rx_state_t            rx_state;
  logic [15:0]          div, tick_cnt;
  logic                 tick, bus_wr, tx_push, rx_pop, clr;
  logic [7:0]           rdata, status;
  logic [DATA_BITS-1:0] tx_head, rx_head, tx_shift, rx_shift;
  logic                 tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
  logic [3:0]           tx_tcnt, rx_tcnt;
  logic [2:0]           tx_bit, rx_bit;
  logic                 tx_par, rx_pbad, tx_idle;
  logic                 rx_s1, rxs, rx_end, par_set, frm_set, ovr_set;
  logic                 overrun, frm_err, par_err;

  assign bus_wr  = iocs && !iorw;
  assign tx_push = bus_wr && (ioaddr == 2'b00);
  assign rx_pop  = iocs && iorw && (ioaddr == 2'b00);
  assign clr     = bus_wr && (ioaddr == 2'b01);

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(databus[DATA_BITS-1:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign rda     = !rx_empty;
  assign tbr     = !tx_full;
  assign tx_idle = (tx_state == TX_IDLE) && tx_empty;
  assign status  = {2'b00, tx_idle, par_err, frm_err, overrun, tbr, rda};

  // bus read mux, visible in the same cycle
  always_comb begin
    rdata = '0;
    unique case (ioaddr)
      2'b00: rdata = rx_empty ? 8'h00 : 8'(rx_head);
      2'b01: rdata = status;
      2'b10: rdata = div[7:0];
      2'b11: rdata = div[15:8];
    endcase
  end

  assign databus = (iocs && iorw) ? rdata : 'z;

  // divisor register, bytes written from the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div <= DIV_RESET;
    else if (bus_wr && ioaddr == 2'b10) div[7:0]  <= databus;
    else if (bus_wr && ioaddr == 2'b11) div[15:8] <= databus;
  end

  // 16x baud tick: down counter that reloads from the divisor whenever it reaches zero
  assign tick = (tick_cnt == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= DIV_RESET;
    else if (tick) tick_cnt <= div;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  // Transmitter. A new character is pulled from the FIFO in IDLE, or at the end of STOP for back-to-back frames.
  assign tx_pop = !tx_empty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tick && tx_tcnt == 4'd15));

  // transmit engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_shift <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      txd      <= 1'b0;
      tx_shift <= tx_head;
      tx_par   <= ^tx_head ^ PARITY_ODD;
      tx_tcnt  <= '0;
    end else if (tick && tx_state != TX_IDLE) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        unique case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            txd      <= tx_shift[0];
            tx_bit   <= '0;
          end
          TX_DATA: begin
            if (tx_bit == 3'(DATA_BITS - 1)) begin
              tx_state <= PARITY_EN ? TX_PAR : TX_STOP;
              txd      <= PARITY_EN ? tx_par : 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end
          TX_PAR: begin
            tx_state <= TX_STOP;
            txd      <= 1'b1;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  assign rx_end  = tick && rx_tcnt == 4'd15;
  assign par_set = (rx_state == RX_PAR) && rx_end && (rxs != (^rx_shift ^ PARITY_ODD));
  assign frm_set = (rx_state == RX_STOP) && rx_end && !rxs;
  assign rx_push = (rx_state == RX_STOP) && rx_end && rxs && !rx_pbad;
  assign ovr_set = rx_push && rx_full && !rx_pop;

  // Receiver. START realigns the counter at the bit centre, so every later sample falls on tick 16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_pbad  <= 1'b0;
    end else begin
      unique case (rx_state)
        RX_IDLE: if (!rxs) begin
          rx_state <= RX_START;
          rx_tcnt  <= '0;
        end
        RX_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_state <= rxs ? RX_IDLE : RX_DATA;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_pbad  <= 1'b0;
          end else begin
            rx_tcnt <= rx_tcnt + 4'd1;
          end
        end
        RX_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == 3'(DATA_BITS - 1)) rx_state <= PARITY_EN ? RX_PAR : RX_STOP;
            else                             rx_bit   <= rx_bit + 3'd1;
          end
        end
        RX_PAR: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_pbad  <= par_set;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= rxs ? RX_IDLE : RX_BRK;
        end
        default: if (rxs) rx_state <= RX_IDLE;
      endcase
    end
  end

  // sticky error flags: write-1-to-clear, and a set in the same cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
      frm_err <= 1'b0;
      par_err <= 1'b0;
    end else begin
      overrun <= ovr_set | (overrun & ~(clr & databus[2]));
      frm_err <= frm_set | (frm_err & ~(clr & databus[3]));
      par_err <= par_set | (par_err & ~(clr & databus[4]));
    end
  end
endmodule

// File: tb/tb_spart_fifo.sv
// Self-checking bench for spart_fifo. It covers bus register access, framing of
// transmitted characters, reception, FIFO limits, error flags and reset.
module tb_spart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       iocs = 1'b0, p_iocs = 1'b0, iorw = 1'b0, oe = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] drv = 8'h00;
  logic       rxd = 1'b1, p_rxd = 1'b1;
  logic       rda, tbr, txd, p_rda, p_tbr, p_txd;
  wire  [7:0] databus, p_databus;

  assign databus   = (oe && iocs)   ? drv : 'z;
  assign p_databus = (oe && p_iocs) ? drv : 'z;

  spart_fifo u_dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  spart_fifo #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
    .clk(clk), .rst(rst), .iocs(p_iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(p_databus), .rda(p_rda), .tbr(p_tbr), .txd(p_txd), .rxd(p_rxd)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_got[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] mon_b;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [7:0] d);
    if (sel) p_iocs = 1'b1; else iocs = 1'b1;
    iorw = 1'b0; ioaddr = a; drv = d; oe = 1'b1;
    clks(1);
    iocs = 1'b0; p_iocs = 1'b0; oe = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, output logic [7:0] d);
    if (sel) p_iocs = 1'b1; else iocs = 1'b1;
    iorw = 1'b1; ioaddr = a;
    #1;
    d = sel ? p_databus : databus;
    clks(1);
    iocs = 1'b0; p_iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) p_rxd = v; else rxd = v;
  endtask

  // One serial character at 16 clocks per bit (DIV=0), LSB first.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic pv, input logic stopv);
    set_rx(sel, 1'b0); clks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]); clks(16);
    end
    if (use_par) begin
      set_rx(sel, pv); clks(16);
    end
    set_rx(sel, stopv); clks(16);
    set_rx(sel, 1'b1); clks(4);
  endtask

  // Wait until every expected character has been seen on txd, then compare the queues.
  task automatic drain_tx(input string nm);
    int n = 0;
    while (tx_got.size() < tx_exp.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    clks(200);
    chk({nm, "_count"}, tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), tx_got[i], tx_exp[i]);
    tx_got.delete();
    tx_exp.delete();
  endtask

  // Decode txd into characters by sampling at the middle of each bit cell.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && txd == 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (16) @(negedge clk);
        tx_got.push_back(mon_b);
      end
    end
  end

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t       vecs[14];
    logic [7:0] d, b;
    logic       exp_bits[10];
    int         n, cnt;
    bit         ovr;

    vecs[0]  = '{1'b0, 2'd1, 8'h00, 8'h22};
    vecs[1]  = '{1'b0, 2'd2, 8'h00, 8'hA2};
    vecs[2]  = '{1'b0, 2'd3, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 2'd2, 8'h34, 8'h00};
    vecs[5]  = '{1'b0, 2'd2, 8'h00, 8'h34};
    vecs[6]  = '{1'b1, 2'd3, 8'h12, 8'h00};
    vecs[7]  = '{1'b0, 2'd3, 8'h00, 8'h12};
    vecs[8]  = '{1'b0, 2'd2, 8'h00, 8'h34};
    vecs[9]  = '{1'b1, 2'd1, 8'h1C, 8'h00};
    vecs[10] = '{1'b0, 2'd1, 8'h00, 8'h22};
    vecs[11] = '{1'b1, 2'd2, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 2'd3, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 2'd2, 8'h00, 8'h00};
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset values
    clks(3);
    chk("rst_txd", txd, 1'b1);
    chk("rst_tbr", tbr, 1'b1);
    chk("rst_rda", rda, 1'b0);
    rst = 1'b1;
    clks(2);

    // register table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) wr(1'b0, vecs[i].addr, vecs[i].data);
      else begin
        rd(1'b0, vecs[i].addr, d);
        chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    wr(1'b1, 2'd2, 8'h00);
    wr(1'b1, 2'd3, 8'h00);
    clks(200);

    // 8'hA5: explicit bit-by-bit line pattern
    wr(1'b0, 2'd0, 8'hA5);
    tx_exp.push_back(8'hA5);
    chk("a5_tbr", tbr, 1'b1);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a5_start_seen", (n < 20), 1'b1);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d", i), txd, exp_bits[i]);
      repeat (16) @(negedge clk);
    end
    @(posedge clk); #1;
    rd(1'b0, 2'd1, d);
    chk("a5_tx_idle", d[5], 1'b1);
    drain_tx("a5");

    // burst of 9 while idle: the engine takes byte 1 at once, so all 9 fit; a 10th is dropped
    clks(20);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      wr(1'b0, 2'd0, b);
      tx_exp.push_back(b);
    end
    chk("burst_tbr_full", tbr, 1'b0);
    wr(1'b0, 2'd0, 8'hEE);
    drain_tx("burst");
    chk("burst_tbr_after", tbr, 1'b1);

    // random TX rounds with random gaps between writes
    for (int r = 0; r < 3; r++) begin
      cnt = $urandom_range(5, 1);
      for (int i = 0; i < cnt; i++) begin
        b = 8'($urandom);
        wr(1'b0, 2'd0, b);
        tx_exp.push_back(b);
        clks($urandom_range(3, 0));
      end
      drain_tx($sformatf("rtx%0d", r));
    end

    // receive 8'h3C
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    chk("rx3c_rda", rda, 1'b1);
    rd(1'b0, 2'd0, d);
    chk("rx3c_data", d, 8'h3C);
    chk("rx3c_rda_after", rda, 1'b0);

    // random receive against a queue model
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_exp.push_back(b);
      send_frame(1'b0, b, 1'b0, 1'b0, 1'b1);
    end
    while (rx_exp.size() > 0) begin
      rd(1'b0, 2'd0, d);
      chk("rrx_data", d, rx_exp.pop_front());
    end
    chk("rrx_rda_empty", rda, 1'b0);

    // overrun: 9 frames into an 8-deep FIFO
    ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (rx_exp.size() < 8) rx_exp.push_back(b);
      else ovr = 1'b1;
      send_frame(1'b0, b, 1'b0, 1'b0, 1'b1);
    end
    rd(1'b0, 2'd1, d);
    chk("ovr_flag", d[2], ovr);
    while (rx_exp.size() > 0) begin
      rd(1'b0, 2'd0, d);
      chk("ovr_data", d, rx_exp.pop_front());
    end
    chk("ovr_rda_empty", rda, 1'b0);
    wr(1'b0, 2'd1, 8'h04);
    rd(1'b0, 2'd1, d);
    chk("ovr_cleared", d[2], 1'b0);

    // glitch: 5 clocks low is rejected, and reception still works afterwards
    rxd = 1'b0; clks(5);
    rxd = 1'b1; clks(40);
    chk("glitch_rda", rda, 1'b0);
    rd(1'b0, 2'd1, d);
    chk("glitch_frm", d[3], 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    rd(1'b0, 2'd0, d);
    chk("glitch_next_data", d, 8'h5A);

    // framing error: stop bit low
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    chk("frm_rda", rda, 1'b0);
    rd(1'b0, 2'd1, d);
    chk("frm_flag", d[3], 1'b1);
    wr(1'b0, 2'd1, 8'h08);
    rd(1'b0, 2'd1, d);
    chk("frm_cleared", d[3], 1'b0);

    // parity on the even-parity instance: 8'h01 needs a parity bit of 1
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    chk("par_bad_rda", p_rda, 1'b0);
    rd(1'b1, 2'd1, d);
    chk("par_bad_flag", d[4], 1'b1);
    b = 8'($urandom);
    send_frame(1'b1, b, 1'b1, ^b, 1'b1);
    chk("par_good_rda", p_rda, 1'b1);
    rd(1'b1, 2'd0, d);
    chk("par_good_data", d, b);

    // reset in the middle of a TX frame, with an unread RX character pending
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("mrst_rda_pre", rda, 1'b1);
    wr(1'b0, 2'd0, 8'h00);
    clks(40);
    chk("mrst_txd_low", txd, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_txd", txd, 1'b1);
    chk("mrst_tbr", tbr, 1'b1);
    chk("mrst_rda", rda, 1'b0);
    clks(3);
    rst = 1'b1;
    clks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
